axi_line_writer: RTL and testbench
==================================

# axi_line_writer

Downstream consumer of the cache write buffer: takes the 128-bit line at the buffer head, issues it as a single 4-beat INCR burst of 32-bit words on the AXI write channels (AW/W/B), and returns a one-cycle completion pulse that pops the buffer head. It is the only AXI write master in the cache subsystem, and it holds at most one line in flight.

## Interface
- AXI_ID, default 4'd1: constant AWID for every burst.
- MAX_RETRY, default 3: maximum re-issues of a failed burst; used only when AXI_LINE_WRITER_RETRY_EN is defined.
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- wb_wen_i  input  1  write buffer has a valid head line pending.
- wb_waddr_i  input  32  head line address, 16-byte aligned.
- wb_wdata_i  input  128  head line data; word k = bits [32k+31:32k].
- wb_done_o  output  1  one-cycle pulse on burst completion; pops the buffer head.
- wr_err_o  output  1  sticky; set on any non-OKAY BRESP; cleared only by reset.
- awid_o 4, awaddr_o 32, awlen_o 8, awsize_o 3, awburst_o 2, awvalid_o 1 (outputs); awready_i 1 (input).
- wdata_o 32, wstrb_o 4, wlast_o 1, wvalid_o 1 (outputs); wready_i 1 (input).
- bid_i 4, bresp_i 2, bvalid_i 1 (inputs); bready_o 1 (output).

## Operation
- The FSM has five states: IDLE, AW, W, B, DONE. All AXI and buffer outputs are registered, decoded from the state register and the beat counter.
- IDLE:
  - If wb_wen_i=1, capture wb_waddr_i and wb_wdata_i into internal registers, then go to AW.
  - Later changes on the buffer side do not affect the burst in flight.
- AW:
  - awvalid_o=1, awaddr_o=captured address, awlen_o=8'd3, awsize_o=3'b010, awburst_o=2'b01, awid_o=AXI_ID.
  - On awvalid_o & awready_i: clear the beat counter and go to W.
- W:
  - wvalid_o=1, wdata_o=captured word[cnt], wstrb_o=4'hF, wlast_o=(cnt==2'd3).
  - On wvalid_o & wready_i: cnt increments. After the beat with cnt==3, go to B.
  - cnt is 2 bits and never wraps within a burst.
- B:
  - bready_o=1. On bvalid_i: check bresp_i.
  - OKAY (2'b00): go to DONE.
  - Otherwise: set wr_err_o, then apply the error handling described under Configuration.
  - bid_i is ignored.
- DONE: wb_done_o=1 for exactly one cycle, then go to IDLE.
- Only one handshake channel is active at a time; AW and W never overlap.
- AXI stability: while a valid is high and its ready is low, all payload outputs of that channel hold constant.
- Reset mid-burst:
  - The FSM returns to IDLE immediately and all valids drop asynchronously.
  - The partial burst is abandoned and wb_done_o is not pulsed. The head stays in the buffer and is re-sent after reset.

## Timing
- Reset values: every output is 0, including awlen_o, awsize_o, awburst_o, awid_o, wdata_o, wstrb_o and wr_err_o. State is IDLE, cnt=0, retry count=0.
- With a zero-wait slave, cycle 0 is IDLE sampling wb_wen_i=1:
  - cycle 1: AW handshake.
  - cycles 2–5: W beats 0–3.
  - cycle 6: B handshake.
  - cycle 7: wb_done_o=1.
  - cycle 8: IDLE samples the next head.
- Minimum issue interval is 8 cycles per line.
- The buffer pops its head on the cycle wb_done_o is high. IDLE in the following cycle therefore sees the new head, or wb_wen_i=0 if the buffer is empty.
- A stall of N cycles on awready_i, wready_i or bvalid_i adds exactly N cycles.

## Configuration
- The feature is controlled by the macro AXI_LINE_WRITER_RETRY_EN.
- Defined:
  - A non-OKAY BRESP with retry count < MAX_RETRY increments the retry count and returns to AW with the captured address and data unchanged. No done pulse is issued.
  - When retry count == MAX_RETRY, go to DONE, which drops the line.
  - The retry count clears on entry to DONE.
- Undefined: any BRESP goes to DONE; the error only sets wr_err_o.

## Structure
- The shared package axi_line_writer_pkg holds:
  - the state enum;
  - the constants AXI_LEN_4BEAT=8'd3, AXI_SIZE_4B=3'b010, AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00;
  - LINE_WORDS=4.
- There is no sub-module. The beat mux and counter are simple enough to stay inline.

## Test plan
- Zero-wait slave:
  - Stimulus: wb_waddr_i=32'h0000_1230, wb_wdata_i=128'h44444444_33333333_22222222_11111111.
  - Required response: awaddr 0x1230, len 3, size 2, burst 1.
  - W beats 11111111, 22222222, 33333333, 44444444, with wlast only on the 4th beat.
  - wb_done_o high in cycle 7.
- Backpressure:
  - Stimulus: awready_i low for 3 cycles, wready_i low for 2 cycles before beat 2, bvalid_i delayed 4 cycles.
  - Required response: payloads stay stable during each stall, and done lands at cycle 7+9=16.
- Input change mid-burst:
  - Stimulus: wb_wdata_i switches to all-F after the AW handshake.
  - Required response: the original words are still sent.
- SLVERR:
  - Stimulus: bresp_i=2'b10.
  - Without the macro: wr_err_o=1 and wb_done_o pulses.
  - With the macro, MAX_RETRY=3: an error-every-time slave produces 4 AW handshakes and then one done pulse. A slave that errors once then returns OKAY produces 2 AW handshakes and then done.
- Reset mid-burst:
  - Stimulus: rst low after beat 1.
  - Required response: all valids drop within the same cycle and no done pulse occurs.
  - After release, the same line is re-sent from AW.
- Back-to-back lines:
  - Stimulus: wb_wen_i held high for 3 lines.
  - Required response: bursts start at cycles 1, 9 and 17, with exactly 3 done pulses.

Source files
------------

// File: rtl/axi_line_writer_pkg.sv
// Shared FSM states and AXI encodings for the cache line writer.
package axi_line_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_DONE
  } state_t;

  localparam logic [7:0] AXI_LEN_4BEAT  = 8'd3;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam int LINE_WORDS = 4;

  // Word k of a 128-bit line sits in bits [32k+31:32k].
  function automatic logic [31:0] line_word(input logic [127:0] line,
                                            input logic [1:0]   idx);
    return line[{idx, 5'd0} +: 32];
  endfunction

endpackage

// File: rtl/axi_line_writer.sv
// Drains one 128-bit write-buffer line as a 4-beat AXI INCR burst.
// Optional bounded re-issue of failed bursts: define AXI_LINE_WRITER_RETRY_EN.
module axi_line_writer
  import axi_line_writer_pkg::*;
#(
  parameter logic [3:0] AXI_ID    = 4'd1,
  parameter int         MAX_RETRY = 3
) (
  input  logic         clk,
  input  logic         rst,

  input  logic         wb_wen_i,
  input  logic [31:0]  wb_waddr_i,
  input  logic [127:0] wb_wdata_i,
  output logic         wb_done_o,
  output logic         wr_err_o,

  output logic [3:0]   awid_o,
  output logic [31:0]  awaddr_o,
  output logic [7:0]   awlen_o,
  output logic [2:0]   awsize_o,
  output logic [1:0]   awburst_o,
  output logic         awvalid_o,
  input  logic         awready_i,

  output logic [31:0]  wdata_o,
  output logic [3:0]   wstrb_o,
  output logic         wlast_o,
  output logic         wvalid_o,
  input  logic         wready_i,

  input  logic [3:0]   bid_i,
  input  logic [1:0]   bresp_i,
  input  logic         bvalid_i,
  output logic         bready_o
);

  state_t       r_state;
  logic [1:0]   r_cnt;
  logic [127:0] r_data;

  logic [3:0]   r_awid;
  logic [31:0]  r_awaddr;
  logic [7:0]   r_awlen;
  logic [2:0]   r_awsize;
  logic [1:0]   r_awburst;
  logic         r_awvalid;
  logic [31:0]  r_wdata;
  logic [3:0]   r_wstrb;
  logic         r_wlast;
  logic         r_wvalid;
  logic         r_bready;
  logic         r_done;
  logic         r_err;

  logic         w_resp_ok;

  assign w_resp_ok = (bresp_i == AXI_RESP_OKAY);

`ifdef AXI_LINE_WRITER_RETRY_EN
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RETRY_W-1:0] r_retry;
  logic               w_retry_left;
  logic               w_unused;

  assign w_retry_left = (r_retry < RETRY_W'(MAX_RETRY));
  assign w_unused     = ^bid_i;
`else
  logic w_unused;

  assign w_unused = ^{bid_i, 1'(MAX_RETRY)};
`endif

  // One register bank for state and every output; valids drop on async reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 2'd0;
      r_data    <= '0;
      r_awid    <= '0;
      r_awaddr  <= '0;
      r_awlen   <= '0;
      r_awsize  <= '0;
      r_awburst <= '0;
      r_awvalid <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_wlast   <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
`ifdef AXI_LINE_WRITER_RETRY_EN
      r_retry   <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (wb_wen_i) begin
            r_data    <= wb_wdata_i;
            r_awid    <= AXI_ID;
            r_awaddr  <= wb_waddr_i;
            r_awlen   <= AXI_LEN_4BEAT;
            r_awsize  <= AXI_SIZE_4B;
            r_awburst <= AXI_BURST_INCR;
            r_awvalid <= 1'b1;
            r_state   <= ST_AW;
          end
        end

        ST_AW: begin
          if (r_awvalid && awready_i) begin
            r_awvalid <= 1'b0;
            r_cnt     <= 2'd0;
            r_wdata   <= line_word(r_data, 2'd0);
            r_wstrb   <= 4'hF;
            r_wlast   <= 1'b0;
            r_wvalid  <= 1'b1;
            r_state   <= ST_W;
          end
        end

        ST_W: begin
          if (r_wvalid && wready_i) begin
            if (r_cnt == 2'(LINE_WORDS - 1)) begin
              r_wvalid <= 1'b0;
              r_wlast  <= 1'b0;
              r_bready <= 1'b1;
              r_state  <= ST_B;
            end else begin
              r_cnt   <= r_cnt + 2'd1;
              r_wdata <= line_word(r_data, r_cnt + 2'd1);
              r_wlast <= (r_cnt == 2'(LINE_WORDS - 2));
            end
          end
        end

        ST_B: begin
          if (r_bready && bvalid_i) begin
            r_bready <= 1'b0;
            if (w_resp_ok) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
`ifdef AXI_LINE_WRITER_RETRY_EN
              r_retry <= '0;
`endif
            end else begin
              r_err <= 1'b1;
`ifdef AXI_LINE_WRITER_RETRY_EN
              // The AW payload registers still hold the captured line, so a retry only re-raises valid.
              if (w_retry_left) begin
                r_retry   <= r_retry + 1'b1;
                r_awvalid <= 1'b1;
                r_state   <= ST_AW;
              end else begin
                r_retry <= '0;
                r_done  <= 1'b1;
                r_state <= ST_DONE;
              end
`else
              r_done  <= 1'b1;
              r_state <= ST_DONE;
`endif
            end
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign awid_o    = r_awid;
  assign awaddr_o  = r_awaddr;
  assign awlen_o   = r_awlen;
  assign awsize_o  = r_awsize;
  assign awburst_o = r_awburst;
  assign awvalid_o = r_awvalid;
  assign wdata_o   = r_wdata;
  assign wstrb_o   = r_wstrb;
  assign wlast_o   = r_wlast;
  assign wvalid_o  = r_wvalid;
  assign bready_o  = r_bready;
  assign wb_done_o = r_done;
  assign wr_err_o  = r_err;

endmodule

// File: tb/tb_axi_line_writer.sv
// Self-checking bench for axi_line_writer: buffer + reactive AXI slave + line-level model.
// Retry expectations follow AXI_LINE_WRITER_RETRY_EN when it is defined.
`timescale 1ns/1ps
module tb_axi_line_writer;

  localparam logic [3:0] TB_AXI_ID    = 4'd1;
  localparam int         TB_MAX_RETRY = 3;

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] data;
  } line_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         wbWen = 1'b0;
  logic [31:0]  wbWaddr = '0;
  logic [127:0] wbWdata = '0;
  logic         wbDone, wrErr;
  logic [3:0]   awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid;
  logic         awready = 1'b0;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast, wvalid;
  logic         wready = 1'b0;
  logic [3:0]   bid = '0;
  logic [1:0]   bresp = '0;
  logic         bvalid = 1'b0;
  logic         bready;

  axi_line_writer #(.AXI_ID(TB_AXI_ID), .MAX_RETRY(TB_MAX_RETRY)) dut (
    .clk(clk), .rst(rst),
    .wb_wen_i(wbWen), .wb_waddr_i(wbWaddr), .wb_wdata_i(wbWdata),
    .wb_done_o(wbDone), .wr_err_o(wrErr),
    .awid_o(awid), .awaddr_o(awaddr), .awlen_o(awlen), .awsize_o(awsize),
    .awburst_o(awburst), .awvalid_o(awvalid), .awready_i(awready),
    .wdata_o(wdata), .wstrb_o(wstrb), .wlast_o(wlast), .wvalid_o(wvalid),
    .wready_i(wready),
    .bid_i(bid), .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int baseCyc = 0;

  // slave configuration and state
  int awStall = 0, wStallBeat = -1, wStallN = 0, bDelay = 0, errLeft = 0;
  int awWait = 0, wWait = 0, wBeat = 0, bWait = 0;
  bit prevWHs = 0, prevBHs = 0;

  // buffer and line-level model
  line_t lineQ[$];
  int    beatIdx = 0, awCount = 0, retryCnt = 0, doneDue = -1, doneCnt = 0;
  bit    expErr = 0, scramble = 0, endLine;
  logic [31:0] awCycQ[$], doneCycQ[$], awPerLine[$], awAddrLog[$], wLog[$], wlastLog[$];

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] wordOf(input logic [127:0] d, input int k);
    return d[(k % 4) * 32 +: 32];
  endfunction

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Reactive slave: drives readies and responses just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      awWait = 0; wWait = 0; wBeat = 0; bWait = 0; prevWHs = 0; prevBHs = 0;
      awready = 0; wready = 0; bvalid = 0; bresp = 0;
    end else begin
      if (prevWHs) begin
        wBeat = (wBeat == 3) ? 0 : wBeat + 1;
        wWait = 0;
      end
      if (prevBHs && errLeft > 0) errLeft--;
      if (awvalid) begin
        awready = (awWait >= awStall);
        if (!awready) awWait++;
      end else begin
        awready = 0; awWait = 0;
      end
      if (wvalid) begin
        if (wBeat == wStallBeat && wWait < wStallN) begin
          wready = 0; wWait++;
        end else wready = 1;
      end else wready = 0;
      if (bready) begin
        if (bWait < bDelay) begin
          bvalid = 0; bWait++;
        end else begin
          bvalid = 1;
          bresp = (errLeft > 0) ? 2'b10 : 2'b00;
          bid = 4'($urandom);
        end
      end else begin
        bvalid = 0; bWait = 0; bresp = 0;
      end
      prevWHs = wvalid && wready;
      prevBHs = bready && bvalid;
    end
  end

  // Compare process: checks outputs against the line-level model every cycle, then drives the buffer.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("validsInReset", {awvalid, wvalid, bready, wbDone}, 4'b0);
      beatIdx = 0; awCount = 0; retryCnt = 0; doneDue = -1; expErr = 0;
    end else begin
      if (awvalid || wvalid)
        checkOutput("awWOverlap", {awvalid, wvalid} == 2'b11, 1'b0);
      if (awvalid) begin
        checkOutput("awPending", lineQ.size() > 0, 1'b1);
        if (lineQ.size() > 0) checkOutput("awaddr", awaddr, lineQ[0].addr);
        checkOutput("awCtrl", {awid, awlen, awsize, awburst}, {TB_AXI_ID, 8'd3, 3'b010, 2'b01});
      end
      if (wvalid) begin
        checkOutput("wPending", lineQ.size() > 0 && beatIdx < 4, 1'b1);
        if (lineQ.size() > 0)
          checkOutput("wBeat", {wdata, wstrb, wlast}, {wordOf(lineQ[0].data, beatIdx), 4'hF, beatIdx == 3});
      end
      checkOutput("wbDone", wbDone, cyc == doneDue);
      checkOutput("wrErr", wrErr, expErr);

      if (awvalid && awready) begin
        awCount++; beatIdx = 0;
        awCycQ.push_back(32'(cyc - baseCyc));
        awAddrLog.push_back(awaddr);
      end
      if (wvalid && wready) begin
        beatIdx++;
        wLog.push_back(wdata);
        wlastLog.push_back({31'd0, wlast});
      end
      if (bready && bvalid) begin
        checkOutput("beatsBeforeB", beatIdx, 4);
        endLine = 1;
        if (bresp != 2'b00) begin
          expErr = 1;
`ifdef AXI_LINE_WRITER_RETRY_EN
          if (retryCnt < TB_MAX_RETRY) begin
            retryCnt++;
            endLine = 0;
          end
`endif
        end
        if (endLine) begin
          doneDue = cyc + 1;
          retryCnt = 0;
        end
      end
      if (wbDone) begin
        doneCnt++;
        doneCycQ.push_back(32'(cyc - baseCyc));
        awPerLine.push_back(32'(awCount));
        awCount = 0;
        if (lineQ.size() > 0) void'(lineQ.pop_front());
      end
    end
    if (lineQ.size() > 0) begin
      wbWen = 1'b1;
      wbWaddr = lineQ[0].addr;
      wbWdata = (scramble && awCount > 0) ? '1 : lineQ[0].data;
    end else begin
      wbWen = 1'b0; wbWaddr = '0; wbWdata = '0;
    end
  end

  task automatic clearLogs();
    awCycQ.delete(); doneCycQ.delete(); awPerLine.delete();
    awAddrLog.delete(); wLog.delete(); wlastLog.delete();
  endtask

  task automatic pushLine(input logic [31:0] addr, input logic [127:0] data);
    line_t l;
    l.addr = addr;
    l.data = data;
    lineQ.push_back(l);
  endtask

  // The cycle this returns in is cycle 0: IDLE samples the head at its end.
  task automatic applyStimulus(input logic [31:0] addr, input logic [127:0] data);
    @(posedge clk); #1;
    clearLogs();
    baseCyc = cyc;
    pushLine(addr, data);
  endtask

  task automatic waitLines(input int target, input int budget);
    int n = 0;
    while (doneCnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (doneCnt < target) begin
      checks++;
      failures++;
      $display("[TB] FAIL doneTimeout actual=%0d required=%0d", doneCnt, target);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  int doneBefore, n;

  initial begin
    $display("[TB] start");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetOutputs",
                {awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready, wbDone, wrErr},
                91'd0);
    @(posedge clk); #2;
    rst = 1'b1;

    // zero-wait slave
    applyStimulus(32'h0000_1230, 128'h44444444_33333333_22222222_11111111);
    waitLines(1, 40);
    checkOutput("zwAwCycle", at(awCycQ, 0), 1);
    checkOutput("zwDoneCycle", at(doneCycQ, 0), 7);
    checkOutput("zwAwAddr", at(awAddrLog, 0), 32'h0000_1230);
    checkOutput("zwBeats", {at(wLog, 3), at(wLog, 2), at(wLog, 1), at(wLog, 0)},
                128'h44444444_33333333_22222222_11111111);
    checkOutput("zwWlast", {at(wlastLog, 3) == 1, at(wlastLog, 2) == 1, at(wlastLog, 1) == 1, at(wlastLog, 0) == 1}, 4'b1000);
    checkOutput("zwErr", wrErr, 1'b0);

    // backpressure on every channel
    awStall = 3; wStallBeat = 2; wStallN = 2; bDelay = 4;
    applyStimulus(32'h0000_2000, 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001);
    waitLines(2, 60);
    awStall = 0; wStallBeat = -1; wStallN = 0; bDelay = 0;
    checkOutput("bpAwCycle", at(awCycQ, 0), 4);
    checkOutput("bpDoneCycle", at(doneCycQ, 0), 16);
    checkOutput("bpBeat2", at(wLog, 2), 32'hCCCC0003);

    // buffer data changes after capture
    scramble = 1;
    applyStimulus(32'h0000_3FF0, 128'h0F0F0F0F_12345678_9ABCDEF0_CAFEBABE);
    waitLines(3, 40);
    scramble = 0;
    checkOutput("scrBeats", {at(wLog, 3), at(wLog, 2), at(wLog, 1), at(wLog, 0)},
                128'h0F0F0F0F_12345678_9ABCDEF0_CAFEBABE);
    checkOutput("scrDoneCycle", at(doneCycQ, 0), 7);

    // one SLVERR then OKAY
    errLeft = 1;
    applyStimulus(32'h0000_4000, 128'h01010101_02020202_03030303_04040404);
    waitLines(4, 80);
`ifdef AXI_LINE_WRITER_RETRY_EN
    checkOutput("errOnceAwCount", at(awPerLine, 0), 2);
`else
    checkOutput("errOnceAwCount", at(awPerLine, 0), 1);
    checkOutput("errOnceDoneCycle", at(doneCycQ, 0), 7);
`endif
    checkOutput("errSticky", wrErr, 1'b1);
    errLeft = 0;

`ifdef AXI_LINE_WRITER_RETRY_EN
    // slave that always errors
    errLeft = 100;
    applyStimulus(32'h0000_5000, 128'h55555555_66666666_77777777_88888888);
    waitLines(5, 120);
    checkOutput("errAlwaysAwCount", at(awPerLine, 0), 4);
    checkOutput("errAlwaysDoneCount", doneCycQ.size(), 1);
    errLeft = 0;
`endif

    // reset after beat 1
    applyStimulus(32'h0000_6010, 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0);
    n = 0;
    while (wLog.size() < 2 && n < 50) begin
      @(posedge clk);
      n++;
    end
    checkOutput("rstReachedBeat1", wLog.size() >= 2, 1'b1);
    doneBefore = doneCnt;
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rstValidsDrop", {awvalid, wvalid, bready, wbDone, wrErr}, 5'b0);
    repeat (2) @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    clearLogs();
    baseCyc = cyc;
    checkOutput("rstNoDone", doneCnt, doneBefore);
    waitLines(doneBefore + 1, 40);
    checkOutput("rstResendAwCycle", at(awCycQ, 0), 1);
    checkOutput("rstResendAddr", at(awAddrLog, 0), 32'h0000_6010);
    checkOutput("rstResendBeat0", at(wLog, 0), 32'hA0A0A0A0);
    checkOutput("rstResendDoneCycle", at(doneCycQ, 0), 7);

    // three lines back to back
    @(posedge clk); #1;
    clearLogs();
    baseCyc = cyc;
    doneBefore = doneCnt;
    pushLine(32'h0001_0000, 128'h1000_0003_1000_0002_1000_0001_1000_0000);
    pushLine(32'h0001_0010, 128'h2000_0003_2000_0002_2000_0001_2000_0000);
    pushLine(32'h0001_0020, 128'h3000_0003_3000_0002_3000_0001_3000_0000);
    waitLines(doneBefore + 3, 80);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("b2bDoneCount", doneCnt - doneBefore, 3);
    checkOutput("b2bAwCycles", {at(awCycQ, 0), at(awCycQ, 1), at(awCycQ, 2)}, {32'd1, 32'd9, 32'd17});
    checkOutput("b2bDoneCycles", {at(doneCycQ, 0), at(doneCycQ, 1), at(doneCycQ, 2)}, {32'd7, 32'd15, 32'd23});
    checkOutput("b2bAddr3", at(awAddrLog, 2), 32'h0001_0020);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
